// File: rtl/osc_saw_meter_pkg.sv
// Shared types and helpers for the sawtooth timing meter.
// The averaging build is selected with the OSC_SAW_METER_AVG_EN macro (see osc_saw_meter.sv).
package osc_saw_meter_pkg;

    typedef enum logic [0:0] {
        SEARCH_E  = 1'b0,
        MEASURE_E = 1'b1
    } meter_state_e;

    // All-ones value of a counter of the given width; counters saturate here.
    function automatic logic [63:0] cnt_max(input int unsigned width);
        cnt_max = (64'd1 << width) - 64'd1;
    endfunction

endpackage

// File: rtl/osc_saw_step_detect.sv
// Previous-sample register plus step/wrap detection for a signed saw stream.
// Both pulses are combinational and valid while the new sample is on the input.
module osc_saw_step_detect #(
    parameter int WAVE_WIDTH_P = 24
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [WAVE_WIDTH_P-1:0] osc_saw_i,
    output logic                    step_o,
    output logic                    wrap_o
);

    logic [WAVE_WIDTH_P-1:0] prev_q;

    // Remember the sample of the previous clk so the current one can be compared against it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= '0;
        end else begin
            prev_q <= osc_saw_i;
        end
    end

    // Any change is a step; a signed drop is the wrap (which is also a step).
    always_comb begin
        step_o = (osc_saw_i != prev_q);
        wrap_o = ($signed(osc_saw_i) < $signed(prev_q));
    end

endmodule

// File: rtl/osc_saw_meter.sv
// Sawtooth timing meter: locks on a wrap, then reports clk cycles per period,
// clk cycles of the final step and steps per period at every following wrap.
// Optional macro OSC_SAW_METER_AVG_EN: average period/step over 2**AVG_LOG2_P periods.
module osc_saw_meter
    import osc_saw_meter_pkg::*;
#(
    parameter int WAVE_WIDTH_P    = 24,
    parameter int COUNTER_WIDTH_P = 28,
    parameter int AVG_LOG2_P      = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WAVE_WIDTH_P-1:0]    osc_saw,
    input  logic                       cr_enable,
    output logic [COUNTER_WIDTH_P-1:0] period_clks,
    output logic [COUNTER_WIDTH_P-1:0] step_clks,
    output logic [COUNTER_WIDTH_P-1:0] steps_per_period,
    output logic                       meas_valid,
    output logic                       locked,
    output logic                       sr_timeout
);

`ifdef OSC_SAW_METER_AVG_EN
    localparam int AVG_SHIFT_C = AVG_LOG2_P;
`else
    // Without averaging every period is its own result (ratio of one).
    localparam int AVG_SHIFT_C = 0 * AVG_LOG2_P;
`endif
    localparam int ACC_W_C = COUNTER_WIDTH_P + AVG_SHIFT_C;
    localparam logic [COUNTER_WIDTH_P-1:0] CNT_MAX_C = COUNTER_WIDTH_P'(cnt_max(COUNTER_WIDTH_P));
    localparam logic [COUNTER_WIDTH_P-1:0] CNT_ONE_C = {{(COUNTER_WIDTH_P-1){1'b0}}, 1'b1};
    localparam logic [AVG_SHIFT_C:0] AVG_LAST_C = (AVG_SHIFT_C+1)'((32'd1 << AVG_SHIFT_C) - 32'd1);
    localparam logic [AVG_SHIFT_C:0] AVG_ONE_C  = {{AVG_SHIFT_C{1'b0}}, 1'b1};

    logic step_s;
    logic wrap_s;
    logic sat_s;

    meter_state_e               state_q,      state_d;
    logic [COUNTER_WIDTH_P-1:0] cycle_cnt_q,  cycle_cnt_d;
    logic [COUNTER_WIDTH_P-1:0] step_cnt_q,   step_cnt_d;
    logic [COUNTER_WIDTH_P-1:0] change_cnt_q, change_cnt_d;
    logic [COUNTER_WIDTH_P-1:0] period_q,     period_d;
    logic [COUNTER_WIDTH_P-1:0] step_clks_q,  step_clks_d;
    logic [COUNTER_WIDTH_P-1:0] spp_q,        spp_d;
    logic                       valid_q,      valid_d;
    logic                       timeout_q,    timeout_d;
    logic [ACC_W_C-1:0]         acc_period_q, acc_period_d;
    logic [ACC_W_C-1:0]         acc_step_q,   acc_step_d;
    logic [AVG_SHIFT_C:0]       avg_cnt_q,    avg_cnt_d;
    logic [ACC_W_C-1:0]         acc_period_sum_s;
    logic [ACC_W_C-1:0]         acc_step_sum_s;

    osc_saw_step_detect #(
        .WAVE_WIDTH_P(WAVE_WIDTH_P)
    ) u_detect (
        .clk       (clk),
        .rst       (rst),
        .osc_saw_i (osc_saw),
        .step_o    (step_s),
        .wrap_o    (wrap_s)
    );

    // Next-state logic: lock on a wrap, count between wraps, publish at wraps, drop lock on disable or saturation.
    always_comb begin
        state_d      = state_q;
        cycle_cnt_d  = cycle_cnt_q;
        step_cnt_d   = step_cnt_q;
        change_cnt_d = change_cnt_q;
        period_d     = period_q;
        step_clks_d  = step_clks_q;
        spp_d        = spp_q;
        valid_d      = 1'b0;
        timeout_d    = 1'b0;
        acc_period_d = acc_period_q;
        acc_step_d   = acc_step_q;
        avg_cnt_d    = avg_cnt_q;

        acc_period_sum_s = acc_period_q + ACC_W_C'(cycle_cnt_q);
        acc_step_sum_s   = acc_step_q + ACC_W_C'(step_cnt_q);
        sat_s = (cycle_cnt_q == CNT_MAX_C) || (step_cnt_q == CNT_MAX_C) ||
                (change_cnt_q == CNT_MAX_C);

        case (state_q)
            SEARCH_E: begin
                acc_period_d = '0;
                acc_step_d   = '0;
                avg_cnt_d    = '0;
                if (cr_enable && wrap_s) begin
                    // The wrap that locks is the first change of the new period.
                    state_d      = MEASURE_E;
                    cycle_cnt_d  = CNT_ONE_C;
                    step_cnt_d   = CNT_ONE_C;
                    change_cnt_d = CNT_ONE_C;
                end else begin
                    state_d      = SEARCH_E;
                    cycle_cnt_d  = '0;
                    step_cnt_d   = '0;
                    change_cnt_d = '0;
                end
            end
            MEASURE_E: begin
                if (!cr_enable || sat_s) begin
                    // Disable takes priority over everything; saturation beats a coincident wrap.
                    timeout_d    = cr_enable;
                    state_d      = SEARCH_E;
                    cycle_cnt_d  = '0;
                    step_cnt_d   = '0;
                    change_cnt_d = '0;
                    acc_period_d = '0;
                    acc_step_d   = '0;
                    avg_cnt_d    = '0;
                end else if (wrap_s) begin
                    cycle_cnt_d  = CNT_ONE_C;
                    step_cnt_d   = CNT_ONE_C;
                    change_cnt_d = CNT_ONE_C;
                    if (avg_cnt_q == AVG_LAST_C) begin
                        period_d     = COUNTER_WIDTH_P'(acc_period_sum_s >> AVG_SHIFT_C);
                        step_clks_d  = COUNTER_WIDTH_P'(acc_step_sum_s >> AVG_SHIFT_C);
                        spp_d        = change_cnt_q;
                        valid_d      = 1'b1;
                        acc_period_d = '0;
                        acc_step_d   = '0;
                        avg_cnt_d    = '0;
                    end else begin
                        acc_period_d = acc_period_sum_s;
                        acc_step_d   = acc_step_sum_s;
                        avg_cnt_d    = avg_cnt_q + AVG_ONE_C;
                    end
                end else begin
                    cycle_cnt_d = cycle_cnt_q + CNT_ONE_C;
                    if (step_s) begin
                        step_cnt_d   = CNT_ONE_C;
                        change_cnt_d = change_cnt_q + CNT_ONE_C;
                    end else begin
                        step_cnt_d   = step_cnt_q + CNT_ONE_C;
                    end
                end
            end
            default: begin
                state_d      = SEARCH_E;
                cycle_cnt_d  = '0;
                step_cnt_d   = '0;
                change_cnt_d = '0;
            end
        endcase
    end

    // State, counters, accumulators and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= SEARCH_E;
            cycle_cnt_q  <= '0;
            step_cnt_q   <= '0;
            change_cnt_q <= '0;
            period_q     <= '0;
            step_clks_q  <= '0;
            spp_q        <= '0;
            valid_q      <= 1'b0;
            timeout_q    <= 1'b0;
            acc_period_q <= '0;
            acc_step_q   <= '0;
            avg_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            cycle_cnt_q  <= cycle_cnt_d;
            step_cnt_q   <= step_cnt_d;
            change_cnt_q <= change_cnt_d;
            period_q     <= period_d;
            step_clks_q  <= step_clks_d;
            spp_q        <= spp_d;
            valid_q      <= valid_d;
            timeout_q    <= timeout_d;
            acc_period_q <= acc_period_d;
            acc_step_q   <= acc_step_d;
            avg_cnt_q    <= avg_cnt_d;
        end
    end

    assign period_clks      = period_q;
    assign step_clks        = step_clks_q;
    assign steps_per_period = spp_q;
    assign meas_valid       = valid_q;
    assign sr_timeout       = timeout_q;
    assign locked           = (state_q == MEASURE_E);

endmodule
